// File: rtl/tl_hdr_parse.sv
// Receive-side TLP header decoder: classifies a 128-bit header as a request
// or a completion, validates completions against the Tag Table, and drops
// bad headers with a single error pulse plus a saturating error count.
module tl_hdr_parse #(
   parameter int unsigned TAG_W             = 8,
   parameter int unsigned MAX_PAYLOAD_BYTES = 256,
   parameter logic [15:0] REQUESTER_ID      = 16'h1234,
   parameter int unsigned ERR_CNT_W         = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [127:0]         hdr_i,
   input  logic                 hdr_valid_i,
   output logic                 hdr_ready_o,
   output logic                 req_valid_o,
   input  logic                 req_ready_i,
   output logic                 req_wr_o,
   output logic                 req_is_cfg_o,
   output logic [63:0]          req_addr_o,
   output logic [9:0]           req_len_o,
   output logic [7:0]           req_tag_o,
   output logic [15:0]          req_rid_o,
   output logic [7:0]           req_be_o,
   output logic                 cpl_valid_o,
   input  logic                 cpl_ready_i,
   output logic [TAG_W-1:0]     cpl_tag_o,
   output logic [2:0]           cpl_status_o,
   output logic [11:0]          cpl_byte_cnt_o,
   output logic                 cpl_has_data_o,
   output logic [9:0]           cpl_len_o,
   output logic [TAG_W-1:0]     tag_chk_o,
   output logic                 tag_chk_valid_o,
   input  logic                 tag_outstanding_i,
   output logic                 tag_release_o,
   output logic                 err_unsup_o,
   output logic                 err_malformed_o,
   output logic                 err_unexp_cpl_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o
);

   localparam int unsigned HDR_W  = 128;
   localparam int unsigned LEN_W  = 10;
   localparam int unsigned DW_W   = 11;
   localparam int unsigned BYTE_W = 13;

   localparam logic [7:0] T_MRD32  = 8'h00;
   localparam logic [7:0] T_MRD64  = 8'h20;
   localparam logic [7:0] T_MWR32  = 8'h40;
   localparam logic [7:0] T_MWR64  = 8'h60;
   localparam logic [7:0] T_CFGRD0 = 8'h04;
   localparam logic [7:0] T_CFGWR0 = 8'h44;
   localparam logic [7:0] T_CPL    = 8'h0A;
   localparam logic [7:0] T_CPLD   = 8'h4A;

   typedef enum logic [1:0] {IDLE, CHECK, OUT_REQ, OUT_CPL} state_t;

   // Length field in DW, where 0 encodes the maximum of 1024.
   function automatic logic [DW_W-1:0] len_dw(input logic [LEN_W-1:0] len);
      return (len == '0) ? DW_W'(1024) : DW_W'(len);
   endfunction

   // Header classification: {unsupported, malformed, is_completion}.
   function automatic logic [2:0] classify(input logic [7:0] t, input logic ep,
                                           input logic [LEN_W-1:0] len);
      logic              sup;
      logic              cpl;
      logic              cfg;
      logic              pay;
      logic [BYTE_W-1:0] bytes;
      sup   = (t == T_MRD32) || (t == T_MRD64) || (t == T_MWR32) || (t == T_MWR64) ||
              (t == T_CFGRD0) || (t == T_CFGWR0) || (t == T_CPL) || (t == T_CPLD);
      cpl   = (t == T_CPL) || (t == T_CPLD);
      cfg   = (t == T_CFGRD0) || (t == T_CFGWR0);
      pay   = (t == T_MWR32) || (t == T_MWR64) || (t == T_CFGWR0) || (t == T_CPLD);
      bytes = {len_dw(len), 2'b00};
      return {!sup,
              ep || (pay && (32'(bytes) > MAX_PAYLOAD_BYTES)) || (cfg && (len != LEN_W'(1))),
              cpl};
   endfunction

   state_t               state_q, state_d;
   logic [HDR_W-1:0]     hdr_q, hdr_d;
   logic                 rel_q, rel_d;
   logic                 hdr_ready_d, req_valid_d, req_wr_d, req_is_cfg_d;
   logic [63:0]          req_addr_d;
   logic [9:0]           req_len_d;
   logic [7:0]           req_tag_d, req_be_d;
   logic [15:0]          req_rid_d;
   logic                 cpl_valid_d, cpl_has_data_d;
   logic [TAG_W-1:0]     cpl_tag_d, tag_chk_d;
   logic [2:0]           cpl_status_d;
   logic [11:0]          cpl_byte_cnt_d;
   logic [9:0]           cpl_len_d;
   logic                 tag_chk_valid_d;
   logic                 err_unsup_d, err_malformed_d, err_unexp_cpl_d;
   logic [ERR_CNT_W-1:0] err_cnt_d;

   logic [7:0]           typ_q;
   logic [2:0]           cls_i, cls_q;
   logic [63:0]          addr_q;
   logic                 rel_cond;
   logic                 unused_hdr;

   assign typ_q = hdr_q[127:120];
   assign cls_i = classify(hdr_i[127:120], hdr_i[110], hdr_i[105:96]);
   assign cls_q = classify(typ_q, hdr_q[110], hdr_q[105:96]);

   // Byte address: config uses DW2 verbatim, 64-bit spans DW2..DW3.
   assign addr_q = ((typ_q == T_CFGRD0) || (typ_q == T_CFGWR0)) ? {32'h0, hdr_q[63:32]} :
                   ((typ_q == T_MRD64) || (typ_q == T_MWR64))   ? {hdr_q[63:32], hdr_q[31:2], 2'b00} :
                                                                  {32'h0, hdr_q[63:34], 2'b00};

   // Final completion: error status, no data, or remaining bytes fit in this payload.
   assign rel_cond = (hdr_q[79:77] != 3'b000) || (typ_q == T_CPL) ||
                     (BYTE_W'(hdr_q[75:64]) <= {len_dw(hdr_q[105:96]), 2'b00});

   assign unused_hdr = ^{hdr_q[119:111], hdr_q[109:106], hdr_q[1:0]};

   // Tag freed in the accept cycle itself so the Tag Table update is atomic with the handshake.
   assign tag_release_o = cpl_valid_o && cpl_ready_i && rel_q;

   // Next-state and next-output logic.
   always_comb begin
      state_d          = state_q;
      hdr_d            = hdr_q;
      rel_d            = rel_q;
      hdr_ready_d      = hdr_ready_o;
      req_valid_d      = req_valid_o;
      req_wr_d         = req_wr_o;
      req_is_cfg_d     = req_is_cfg_o;
      req_addr_d       = req_addr_o;
      req_len_d        = req_len_o;
      req_tag_d        = req_tag_o;
      req_rid_d        = req_rid_o;
      req_be_d         = req_be_o;
      cpl_valid_d      = cpl_valid_o;
      cpl_tag_d        = cpl_tag_o;
      cpl_status_d     = cpl_status_o;
      cpl_byte_cnt_d   = cpl_byte_cnt_o;
      cpl_has_data_d   = cpl_has_data_o;
      cpl_len_d        = cpl_len_o;
      tag_chk_d        = tag_chk_o;
      tag_chk_valid_d  = 1'b0;
      err_unsup_d      = 1'b0;
      err_malformed_d  = 1'b0;
      err_unexp_cpl_d  = 1'b0;
      err_cnt_d        = err_cnt_o;

      case (state_q)
         IDLE: begin
            hdr_ready_d = 1'b1;
            if (hdr_valid_i && hdr_ready_o) begin
               hdr_d           = hdr_i;
               hdr_ready_d     = 1'b0;
               tag_chk_d       = hdr_i[40 +: TAG_W];
               tag_chk_valid_d = cls_i[0] && !cls_i[2] && !cls_i[1];
               state_d         = CHECK;
            end
         end
         CHECK: begin
            state_d     = IDLE;
            hdr_ready_d = 1'b1;
            if (cls_q[2]) begin
               err_unsup_d = 1'b1;
            end else if (cls_q[1]) begin
               err_malformed_d = 1'b1;
            end else if (cls_q[0]) begin
               if ((hdr_q[63:48] != REQUESTER_ID) || !tag_outstanding_i) begin
                  err_unexp_cpl_d = 1'b1;
               end else begin
                  state_d        = OUT_CPL;
                  hdr_ready_d    = 1'b0;
                  cpl_valid_d    = 1'b1;
                  cpl_tag_d      = hdr_q[40 +: TAG_W];
                  cpl_status_d   = hdr_q[79:77];
                  cpl_byte_cnt_d = hdr_q[75:64];
                  cpl_has_data_d = (typ_q == T_CPLD);
                  cpl_len_d      = hdr_q[105:96];
                  rel_d          = rel_cond;
               end
            end else begin
               state_d      = OUT_REQ;
               hdr_ready_d  = 1'b0;
               req_valid_d  = 1'b1;
               req_wr_d     = typ_q[6];
               req_is_cfg_d = (typ_q == T_CFGRD0) || (typ_q == T_CFGWR0);
               req_addr_d   = addr_q;
               req_len_d    = hdr_q[105:96];
               req_rid_d    = hdr_q[95:80];
               req_tag_d    = hdr_q[79:72];
               req_be_d     = hdr_q[71:64];
            end
            if ((err_unsup_d || err_malformed_d || err_unexp_cpl_d) &&
                (err_cnt_o != {ERR_CNT_W{1'b1}})) begin
               err_cnt_d = err_cnt_o + ERR_CNT_W'(1);
            end
         end
         OUT_REQ: begin
            if (req_ready_i) begin
               req_valid_d = 1'b0;
               hdr_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end
         OUT_CPL: begin
            if (cpl_ready_i) begin
               cpl_valid_d = 1'b0;
               rel_d       = 1'b0;
               hdr_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset discards any held header.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         hdr_q           <= '0;
         rel_q           <= 1'b0;
         hdr_ready_o     <= 1'b0;
         req_valid_o     <= 1'b0;
         req_wr_o        <= 1'b0;
         req_is_cfg_o    <= 1'b0;
         req_addr_o      <= '0;
         req_len_o       <= '0;
         req_tag_o       <= '0;
         req_rid_o       <= '0;
         req_be_o        <= '0;
         cpl_valid_o     <= 1'b0;
         cpl_tag_o       <= '0;
         cpl_status_o    <= '0;
         cpl_byte_cnt_o  <= '0;
         cpl_has_data_o  <= 1'b0;
         cpl_len_o       <= '0;
         tag_chk_o       <= '0;
         tag_chk_valid_o <= 1'b0;
         err_unsup_o     <= 1'b0;
         err_malformed_o <= 1'b0;
         err_unexp_cpl_o <= 1'b0;
         err_cnt_o       <= '0;
      end else begin
         state_q         <= state_d;
         hdr_q           <= hdr_d;
         rel_q           <= rel_d;
         hdr_ready_o     <= hdr_ready_d;
         req_valid_o     <= req_valid_d;
         req_wr_o        <= req_wr_d;
         req_is_cfg_o    <= req_is_cfg_d;
         req_addr_o      <= req_addr_d;
         req_len_o       <= req_len_d;
         req_tag_o       <= req_tag_d;
         req_rid_o       <= req_rid_d;
         req_be_o        <= req_be_d;
         cpl_valid_o     <= cpl_valid_d;
         cpl_tag_o       <= cpl_tag_d;
         cpl_status_o    <= cpl_status_d;
         cpl_byte_cnt_o  <= cpl_byte_cnt_d;
         cpl_has_data_o  <= cpl_has_data_d;
         cpl_len_o       <= cpl_len_d;
         tag_chk_o       <= tag_chk_d;
         tag_chk_valid_o <= tag_chk_valid_d;
         err_unsup_o     <= err_unsup_d;
         err_malformed_o <= err_malformed_d;
         err_unexp_cpl_o <= err_unexp_cpl_d;
         err_cnt_o       <= err_cnt_d;
      end
   end

endmodule

// File: tb/tb_tl_hdr_parse.sv
// Directed self-checking bench for tl_hdr_parse.
module tb_tl_hdr_parse;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [127:0] hdr_i = '0;
   logic         hdr_valid_i = 1'b0;
   logic         hdr_ready_o;
   logic         req_valid_o;
   logic         req_ready_i = 1'b0;
   logic         req_wr_o, req_is_cfg_o;
   logic [63:0]  req_addr_o;
   logic [9:0]   req_len_o;
   logic [7:0]   req_tag_o;
   logic [15:0]  req_rid_o;
   logic [7:0]   req_be_o;
   logic         cpl_valid_o;
   logic         cpl_ready_i = 1'b0;
   logic [7:0]   cpl_tag_o;
   logic [2:0]   cpl_status_o;
   logic [11:0]  cpl_byte_cnt_o;
   logic         cpl_has_data_o;
   logic [9:0]   cpl_len_o;
   logic [7:0]   tag_chk_o;
   logic         tag_chk_valid_o;
   logic         tag_outstanding_i;
   logic         tag_release_o;
   logic         err_unsup_o, err_malformed_o, err_unexp_cpl_o;
   logic [7:0]   err_cnt_o;

   logic [255:0] outstanding = '0;
   int           checks = 0;
   int           failures = 0;
   int           cyc = 0;
   int           acc_cyc = 0;

   assign tag_outstanding_i = outstanding[tag_chk_o];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tl_hdr_parse dut (
      .clk(clk), .rst_n(rst_n), .hdr_i(hdr_i), .hdr_valid_i(hdr_valid_i), .hdr_ready_o(hdr_ready_o),
      .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_wr_o(req_wr_o),
      .req_is_cfg_o(req_is_cfg_o), .req_addr_o(req_addr_o), .req_len_o(req_len_o),
      .req_tag_o(req_tag_o), .req_rid_o(req_rid_o), .req_be_o(req_be_o),
      .cpl_valid_o(cpl_valid_o), .cpl_ready_i(cpl_ready_i), .cpl_tag_o(cpl_tag_o),
      .cpl_status_o(cpl_status_o), .cpl_byte_cnt_o(cpl_byte_cnt_o),
      .cpl_has_data_o(cpl_has_data_o), .cpl_len_o(cpl_len_o),
      .tag_chk_o(tag_chk_o), .tag_chk_valid_o(tag_chk_valid_o),
      .tag_outstanding_i(tag_outstanding_i), .tag_release_o(tag_release_o),
      .err_unsup_o(err_unsup_o), .err_malformed_o(err_malformed_o),
      .err_unexp_cpl_o(err_unexp_cpl_o), .err_cnt_o(err_cnt_o)
   );

   function automatic logic [127:0] mk_req(input logic [7:0] t, input logic ep, input logic [9:0] len,
                                           input logic [15:0] rid, input logic [7:0] tag,
                                           input logic [7:0] be, input logic [63:0] lo);
      logic [127:0] h;
      h = '0;
      h[127:120] = t; h[110] = ep; h[105:96] = len; h[95:80] = rid;
      h[79:72] = tag; h[71:64] = be; h[63:0] = lo;
      return h;
   endfunction

   function automatic logic [127:0] mk_cpl(input logic [7:0] t, input logic [9:0] len,
                                           input logic [2:0] st, input logic [11:0] bc,
                                           input logic [15:0] rid, input logic [7:0] tag);
      logic [127:0] h;
      h = '0;
      h[127:120] = t; h[105:96] = len; h[95:80] = 16'h00AA; h[79:77] = st;
      h[75:64] = bc; h[63:48] = rid; h[47:40] = tag;
      return h;
   endfunction

   // Present one header; returns at the negedge of the CHECK cycle.
   task automatic send(input logic [127:0] h);
      int n = 0;
      while (!hdr_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (hdr_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL send_timeout hdr_ready_o=%0b required 1", hdr_ready_o);
      end
      hdr_i = h;
      hdr_valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      hdr_valid_i = 1'b0;
      acc_cyc = cyc;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({hdr_ready_o, req_valid_o, cpl_valid_o, tag_chk_valid_o, tag_release_o,
           err_unsup_o, err_malformed_o, err_unexp_cpl_o} !== 8'h00) begin
         failures++;
         $display("FAIL reset_flags got=%b required 00000000", {hdr_ready_o, req_valid_o, cpl_valid_o,
                  tag_chk_valid_o, tag_release_o, err_unsup_o, err_malformed_o, err_unexp_cpl_o});
      end
      checks++;
      if (err_cnt_o !== 8'h00 || req_addr_o !== 64'h0) begin
         failures++;
         $display("FAIL reset_data err_cnt=%h addr=%h required 0", err_cnt_o, req_addr_o);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (hdr_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready got=%b required 1", hdr_ready_o);
      end
   endtask

   task automatic test_mwr32();
      req_ready_i = 1'b1;
      send(mk_req(8'h40, 1'b0, 10'd4, 16'hABCD, 8'h11, 8'hFF, {32'h0000_1000, 32'h0}));
      checks++;
      if (req_valid_o !== 1'b0 || hdr_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL mwr32_check_cycle valid=%b ready=%b required 0 0", req_valid_o, hdr_ready_o);
      end
      @(negedge clk);
      checks++;
      if ({req_valid_o, req_wr_o, req_is_cfg_o} !== 3'b110 || req_addr_o !== 64'h0000_0000_0000_1000 ||
          req_len_o !== 10'd4) begin
         failures++;
         $display("FAIL mwr32_out v/wr/cfg=%b addr=%h len=%0d required 110 %h 4",
                  {req_valid_o, req_wr_o, req_is_cfg_o}, req_addr_o, req_len_o, 64'h1000);
      end
      checks++;
      if ({req_rid_o, req_tag_o, req_be_o} !== 32'hABCD_11FF) begin
         failures++;
         $display("FAIL mwr32_fields got=%h required abcd11ff", {req_rid_o, req_tag_o, req_be_o});
      end
      @(negedge clk);
      checks++;
      if (req_valid_o !== 1'b0 || hdr_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL mwr32_done valid=%b ready=%b required 0 1", req_valid_o, hdr_ready_o);
      end
   endtask

   task automatic test_mrd64_cfg();
      req_ready_i = 1'b1;
      send(mk_req(8'h20, 1'b0, 10'd1, 16'h1111, 8'h05, 8'h0F, 64'h0000_0001_0000_0042));
      @(negedge clk);
      checks++;
      if (req_valid_o !== 1'b1 || req_addr_o !== 64'h0000_0001_0000_0040 || req_tag_o !== 8'h05 ||
          req_wr_o !== 1'b0 || req_is_cfg_o !== 1'b0) begin
         failures++;
         $display("FAIL mrd64 valid=%b addr=%h tag=%h wr=%b cfg=%b required 1 %h 05 0 0",
                  req_valid_o, req_addr_o, req_tag_o, req_wr_o, req_is_cfg_o, 64'h1_0000_0040);
      end
      @(negedge clk);
      send(mk_req(8'h44, 1'b0, 10'd1, 16'h2222, 8'h06, 8'h0F, {32'h0100_0013, 32'h0}));
      @(negedge clk);
      checks++;
      if (req_valid_o !== 1'b1 || req_addr_o !== 64'h0000_0000_0100_0013 || req_wr_o !== 1'b1 ||
          req_is_cfg_o !== 1'b1) begin
         failures++;
         $display("FAIL cfgwr0 valid=%b addr=%h wr=%b cfg=%b required 1 %h 1 1",
                  req_valid_o, req_addr_o, req_wr_o, req_is_cfg_o, 64'h0100_0013);
      end
      @(negedge clk);
      send(mk_req(8'h40, 1'b0, 10'd64, 16'h3333, 8'h07, 8'hFF, {32'h0000_2000, 32'h0}));
      @(negedge clk);
      checks++;
      if (req_valid_o !== 1'b1 || err_malformed_o !== 1'b0 || req_len_o !== 10'd64) begin
         failures++;
         $display("FAIL mwr_256B valid=%b mal=%b len=%0d required 1 0 64",
                  req_valid_o, err_malformed_o, req_len_o);
      end
      @(negedge clk);
   endtask

   task automatic test_cpl_release();
      logic [127:0] hv [3];
      logic         rel [3];
      outstanding = '0;
      outstanding[7] = 1'b1;
      cpl_ready_i = 1'b0;
      send(mk_cpl(8'h4A, 10'd4, 3'd0, 12'd16, 16'h1234, 8'h07));
      checks++;
      if (tag_chk_valid_o !== 1'b1 || tag_chk_o !== 8'h07) begin
         failures++;
         $display("FAIL cpl_lookup valid=%b tag=%h required 1 07", tag_chk_valid_o, tag_chk_o);
      end
      @(negedge clk);
      checks++;
      if (cpl_valid_o !== 1'b1 || cpl_tag_o !== 8'h07 || cpl_status_o !== 3'd0 ||
          cpl_byte_cnt_o !== 12'd16 || cpl_has_data_o !== 1'b1 || cpl_len_o !== 10'd4 ||
          tag_release_o !== 1'b0 || req_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL cpld_out v=%b tag=%h st=%0d bc=%0d d=%b len=%0d rel=%b req=%b required 1 07 0 16 1 4 0 0",
                  cpl_valid_o, cpl_tag_o, cpl_status_o, cpl_byte_cnt_o, cpl_has_data_o, cpl_len_o,
                  tag_release_o, req_valid_o);
      end
      cpl_ready_i = 1'b1;
      #1;
      checks++;
      if (tag_release_o !== 1'b1) begin
         failures++;
         $display("FAIL cpld_release got=%b required 1", tag_release_o);
      end
      @(negedge clk);
      checks++;
      if (cpl_valid_o !== 1'b0 || tag_release_o !== 1'b0) begin
         failures++;
         $display("FAIL cpld_done valid=%b rel=%b required 0 0", cpl_valid_o, tag_release_o);
      end
      cpl_ready_i = 1'b0;
      hv[0] = mk_cpl(8'h4A, 10'd4, 3'd0, 12'd32, 16'h1234, 8'h07);  rel[0] = 1'b0;
      hv[1] = mk_cpl(8'h0A, 10'd1, 3'd0, 12'd100, 16'h1234, 8'h07); rel[1] = 1'b1;
      hv[2] = mk_cpl(8'h4A, 10'd4, 3'd1, 12'd32, 16'h1234, 8'h07);  rel[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send(hv[i]);
         @(negedge clk);
         checks++;
         if (cpl_valid_o !== 1'b1 || tag_release_o !== 1'b0) begin
            failures++;
            $display("FAIL cpl_hold[%0d] valid=%b rel=%b required 1 0", i, cpl_valid_o, tag_release_o);
         end
         cpl_ready_i = 1'b1;
         #1;
         checks++;
         if (tag_release_o !== rel[i]) begin
            failures++;
            $display("FAIL cpl_release[%0d] got=%b required %b", i, tag_release_o, rel[i]);
         end
         @(negedge clk);
         cpl_ready_i = 1'b0;
      end
   endtask

   task automatic test_errors();
      logic [127:0] hv [8];
      logic [2:0]   ex [8];
      logic         chk [8];
      outstanding = '0;
      outstanding[7] = 1'b1;
      req_ready_i = 1'b1;
      cpl_ready_i = 1'b1;
      hv[0] = mk_cpl(8'h0A, 10'd1, 3'd0, 12'd4, 16'h1234, 8'h09);            ex[0] = 3'b001; chk[0] = 1'b1;
      hv[1] = mk_cpl(8'h4A, 10'd1, 3'd0, 12'd4, 16'h4321, 8'h07);            ex[1] = 3'b001; chk[1] = 1'b1;
      hv[2] = mk_req(8'h30, 1'b1, 10'd1, 16'h0, 8'h0, 8'h0, 64'h0);          ex[2] = 3'b100; chk[2] = 1'b0;
      hv[3] = mk_req(8'h40, 1'b0, 10'd128, 16'h0, 8'h0, 8'hFF, 64'h0);       ex[3] = 3'b010; chk[3] = 1'b0;
      hv[4] = mk_req(8'h44, 1'b0, 10'd2, 16'h0, 8'h0, 8'hFF, 64'h0);         ex[4] = 3'b010; chk[4] = 1'b0;
      hv[5] = mk_req(8'h00, 1'b1, 10'd1, 16'h0, 8'h0, 8'h0F, 64'h0);         ex[5] = 3'b010; chk[5] = 1'b0;
      hv[6] = mk_cpl(8'h4A, 10'd0, 3'd0, 12'd4, 16'h1234, 8'h07);            ex[6] = 3'b010; chk[6] = 1'b0;
      hv[7] = mk_req(8'h60, 1'b0, 10'd0, 16'h0, 8'h0, 8'hFF, 64'h0);         ex[7] = 3'b010; chk[7] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         send(hv[i]);
         checks++;
         if (tag_chk_valid_o !== chk[i]) begin
            failures++;
            $display("FAIL err_lookup[%0d] got=%b required %b", i, tag_chk_valid_o, chk[i]);
         end
         @(negedge clk);
         checks++;
         if ({err_unsup_o, err_malformed_o, err_unexp_cpl_o} !== ex[i] || req_valid_o !== 1'b0 ||
             cpl_valid_o !== 1'b0 || err_cnt_o !== 8'(i + 1)) begin
            failures++;
            $display("FAIL err[%0d] flags=%b req=%b cpl=%b cnt=%0d required %b 0 0 %0d", i,
                     {err_unsup_o, err_malformed_o, err_unexp_cpl_o}, req_valid_o, cpl_valid_o,
                     err_cnt_o, ex[i], i + 1);
         end
         @(negedge clk);
         checks++;
         if ({err_unsup_o, err_malformed_o, err_unexp_cpl_o} !== 3'b000) begin
            failures++;
            $display("FAIL err_pulse[%0d] flags=%b required 000", i,
                     {err_unsup_o, err_malformed_o, err_unexp_cpl_o});
         end
      end
      for (int i = 0; i < 247; i++) send(mk_req(8'h30, 1'b0, 10'd1, 16'h0, 8'h0, 8'h0, 64'h0));
      @(negedge clk);
      checks++;
      if (err_cnt_o !== 8'hFF) begin
         failures++;
         $display("FAIL err_cnt_255 got=%h required ff", err_cnt_o);
      end
      for (int i = 0; i < 5; i++) send(mk_req(8'h30, 1'b0, 10'd1, 16'h0, 8'h0, 8'h0, 64'h0));
      @(negedge clk);
      checks++;
      if (err_cnt_o !== 8'hFF || err_unsup_o !== 1'b1) begin
         failures++;
         $display("FAIL err_cnt_sat cnt=%h unsup=%b required ff 1", err_cnt_o, err_unsup_o);
      end
      cpl_ready_i = 1'b0;
   endtask

   task automatic test_backpressure();
      req_ready_i = 1'b0;
      send(mk_req(8'h60, 1'b0, 10'd2, 16'h5555, 8'h33, 8'hF0, 64'hDEAD_BEEF_0000_0107));
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (req_valid_o !== 1'b1 || req_addr_o !== 64'hDEAD_BEEF_0000_0104 || req_len_o !== 10'd2 ||
             req_tag_o !== 8'h33 || req_be_o !== 8'hF0 || hdr_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL stall[%0d] v=%b addr=%h len=%0d tag=%h be=%h rdy=%b required 1 %h 2 33 f0 0",
                     k, req_valid_o, req_addr_o, req_len_o, req_tag_o, req_be_o, hdr_ready_o,
                     64'hDEAD_BEEF_0000_0104);
         end
         @(negedge clk);
      end
      req_ready_i = 1'b1;
      @(negedge clk);
      checks++;
      if (req_valid_o !== 1'b0 || hdr_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL stall_release valid=%b ready=%b required 0 1", req_valid_o, hdr_ready_o);
      end
   endtask

   task automatic test_back_to_back();
      int a;
      req_ready_i = 1'b1;
      send(mk_req(8'h00, 1'b0, 10'd1, 16'h0001, 8'hA1, 8'h0F, 64'h0));
      a = acc_cyc;
      send(mk_req(8'h00, 1'b0, 10'd1, 16'h0002, 8'hA2, 8'h0F, 64'h0));
      checks++;
      if (acc_cyc - a !== 3) begin
         failures++;
         $display("FAIL b2b_spacing got=%0d required 3", acc_cyc - a);
      end
      @(negedge clk);
      checks++;
      if (req_valid_o !== 1'b1 || req_tag_o !== 8'hA2 || req_rid_o !== 16'h0002) begin
         failures++;
         $display("FAIL b2b_second valid=%b tag=%h rid=%h required 1 a2 0002", req_valid_o, req_tag_o, req_rid_o);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_in_cpl();
      outstanding = '0;
      outstanding[7] = 1'b1;
      cpl_ready_i = 1'b0;
      send(mk_cpl(8'h4A, 10'd4, 3'd0, 12'd16, 16'h1234, 8'h07));
      @(negedge clk);
      checks++;
      if (cpl_valid_o !== 1'b1) begin
         failures++;
         $display("FAIL rst_cpl_pre valid=%b required 1", cpl_valid_o);
      end
      cpl_ready_i = 1'b1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({tag_release_o, cpl_valid_o, req_valid_o, hdr_ready_o, tag_chk_valid_o} !== 5'b0 ||
          err_cnt_o !== 8'h00 || cpl_tag_o !== 8'h00 || cpl_byte_cnt_o !== 12'h0) begin
         failures++;
         $display("FAIL rst_cpl_outs rel/cv/rv/rdy/chk=%b cnt=%h tag=%h bc=%h required 00000 00 00 000",
                  {tag_release_o, cpl_valid_o, req_valid_o, hdr_ready_o, tag_chk_valid_o},
                  err_cnt_o, cpl_tag_o, cpl_byte_cnt_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      cpl_ready_i = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (hdr_ready_o !== 1'b1 || cpl_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL rst_cpl_after ready=%b valid=%b required 1 0", hdr_ready_o, cpl_valid_o);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_mwr32();
      test_mrd64_cfg();
      test_cpl_release();
      test_errors();
      test_backpressure();
      test_back_to_back();
      test_reset_in_cpl();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
